// File: rtl/mem_port_wb_arbiter.sv
// Round-robin bridge from NUM_PORTS core memory ports to one Wishbone classic master, one transaction in flight.
// Optional bus watchdog: define TIMEOUT_EN to force an error completion after TIMEOUT_CYCLES bus cycles.
module mem_port_wb_arbiter #(
    parameter int                   NUM_PORTS      = 2,
    parameter int                   ADDR_WIDTH     = 32,
    parameter int                   DATA_WIDTH     = 32,
    parameter logic [NUM_PORTS-1:0] READ_ONLY_MASK = 'b01,
    parameter int                   TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk_core,
    input  logic                              rst_core,
    input  logic [NUM_PORTS-1:0]              req_i,
    input  logic [NUM_PORTS-1:0]              we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] wstrb_i,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic [NUM_PORTS-1:0]              valid_o,
    output logic                              err_o,
    output logic                              wb_cyc_o,
    output logic                              wb_stb_o,
    output logic                              wb_we_o,
    output logic [DATA_WIDTH/8-1:0]           wb_wstrb_o,
    output logic [ADDR_WIDTH-1:0]             wb_addr_o,
    output logic [DATA_WIDTH-1:0]             wb_data_o,
    input  logic [DATA_WIDTH-1:0]             wb_data_i,
    input  logic                              wb_ack_i,
    input  logic                              wb_err_i
);
    // state | meaning
    // IDLE  | sample req_i, grant next requester after 'last', latch its fields
    // BUS   | Wishbone cycle open, wait for ack/err (or watchdog expiry)
    // RESP  | one-cycle valid_o pulse to the granted port

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [PTR_WIDTH-1:0]   last;
    logic [PTR_WIDTH-1:0]   pick;
    logic                   any_req;
    logic                   pick_write;
    logic                   bus_done;
    logic                   bus_timeout;
    int                     cand;

    logic                   lat_we;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic [STRB_WIDTH-1:0]  lat_wstrb;
    logic [DATA_WIDTH-1:0]  rdata;
    logic                   err;

    // Search starts one past the previous winner so every requester is served in turn.
    always_comb begin
        any_req = 1'b0;
        pick    = last;
        cand    = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = int'(last) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!any_req && req_i[PTR_WIDTH'(cand)]) begin
                any_req = 1'b1;
                pick    = PTR_WIDTH'(cand);
            end
        end
    end

    assign pick_write = we_i[pick] & ~READ_ONLY_MASK[pick];
    assign bus_done   = wb_ack_i | wb_err_i;

`ifdef TIMEOUT_EN
    localparam int TMR_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMR_WIDTH-1:0] tmr;

    // Loaded while idle so the first BUS cycle already counts; expiry on the terminal count.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            tmr <= '0;
        end else if (state == IDLE) begin
            tmr <= TMR_WIDTH'(TIMEOUT_CYCLES - 1);
        end else if (state == BUS && tmr != '0) begin
            tmr <= tmr - TMR_WIDTH'(1);
        end
    end

    assign bus_timeout = (state == BUS) && (tmr == '0) && !bus_done;
`else
    assign bus_timeout = 1'b0;
`endif

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (bus_done || bus_timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read-only forcing is applied at latch time, so the bus only ever sees cleaned fields.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            last      <= PTR_WIDTH'(NUM_PORTS - 1);
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last      <= pick;
                        lat_we    <= pick_write;
                        lat_addr  <= addr_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                        lat_wdata <= pick_write ? wdata_i[int'(pick)*DATA_WIDTH +: DATA_WIDTH] : '0;
                        lat_wstrb <= pick_write ? wstrb_i[int'(pick)*STRB_WIDTH +: STRB_WIDTH] : '0;
                    end
                end
                BUS: begin
                    if (bus_done) begin
                        rdata <= wb_data_i;
                        err   <= wb_err_i & ~wb_ack_i;
                    end else if (bus_timeout) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wb_cyc_o   = (state == BUS);
    assign wb_stb_o   = wb_cyc_o;
    assign wb_we_o    = lat_we;
    assign wb_addr_o  = lat_addr;
    assign wb_data_o  = lat_wdata;
    assign wb_wstrb_o = lat_wstrb;
    assign rdata_o    = rdata;
    assign err_o      = err;
    assign valid_o    = (state == RESP) ? (NUM_PORTS'(1) << last) : '0;

endmodule

// File: doc/mem_port_wb_arbiter.md
Name: mem_port_wb_arbiter

Overview:
Parametrised bridge from NUM_PORTS core-side en/valid memory ports (instruction fetch, data load/store, …) to one shared Wishbone classic master port (cyc/stb/we/wstrb/addr/data/ack).
- Fair round-robin arbitration; one outstanding transaction at a time.
- Per-port read-only forcing.
- Error response path.
- Sits between a processor core and the Controller memory bus when the core has more memory ports than the bus exposes.

Parameters:
NUM_PORTS, 2, number of requester ports (1..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (multiple of 8)
READ_ONLY_MASK, 'b01, bit p=1 forces port p to read-only (we and wstrb ignored)
TIMEOUT_CYCLES, 1024, bus cycles before forced error (only with TIMEOUT_EN)

Ports:
clk_core  in  1  core clock; all logic rising-edge
rst_core  in  1  reset, asynchronous, active-high
req_i  in  NUM_PORTS  per-port request, level held until valid_o
we_i  in  NUM_PORTS  per-port write enable
addr_i  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
wdata_i  in  NUM_PORTS*DATA_WIDTH  packed write data
wstrb_i  in  NUM_PORTS*DATA_WIDTH/8  packed byte strobes
rdata_o  out  DATA_WIDTH  read data, shared, qualified by valid_o
valid_o  out  NUM_PORTS  one-cycle completion pulse, one-hot
err_o  out  1  completion is an error, qualified by valid_o
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe, equal to wb_cyc_o
wb_we_o  out  1  write
wb_wstrb_o  out  DATA_WIDTH/8  byte enables
wb_addr_o  out  ADDR_WIDTH  address
wb_data_o  out  DATA_WIDTH  write data
wb_data_i  in  DATA_WIDTH  read data
wb_ack_i  in  1  ack
wb_err_i  in  1  bus error, treated as termination

Behaviour:
Reset:
- All outputs 0; state IDLE; round-robin pointer last = NUM_PORTS-1, so port 0 wins first.
- Reset mid-transaction abandons it: cyc drops immediately (asynchronous) and no valid_o is produced.

States:
- IDLE:
  - Sample req_i.
  - If any bit is set, grant the first set bit searching from last+1 upward with wrap-around.
  - Latch the granted port's we/addr/wdata/wstrb into registers.
  - Set last = grant and go to BUS.
  - Outputs are registered: wb_cyc_o/stb_o rise the cycle after the sampling edge.
- BUS:
  - wb_cyc_o = wb_stb_o = 1.
  - Latched fields are driven and held stable for the whole cycle.
  - If wb_ack_i or wb_err_i is high at an edge: capture wb_data_i into rdata_o, set err_o = wb_err_i & ~wb_ack_i (ack wins when both are high), drop cyc/stb, go to RESP.
- RESP:
  - valid_o[grant] = 1 for exactly this cycle.
  - Next state is IDLE.
  - The requester drops req_i at the edge ending RESP, so the following IDLE cycle never sees a stale request.

Latency and throughput:
- Request sampled at edge N → cyc high in cycle N+1.
- Ack at edge M → valid in cycle M+1 → IDLE in cycle M+2.
- Zero-wait slave: 3 cycles per transaction, back-to-back.

Field rules:
- Reads (we=0, or port in READ_ONLY_MASK): wb_we_o = 0, wb_wstrb_o = 0, wb_data_o = 0.
- Writes: wb_wstrb_o = latched wstrb; a write with wstrb = 0 still runs a bus cycle.
- rdata_o holds its value until the next completion; it is undefined meaning for writes, but still updated from wb_data_i.

Boundary conditions:
- wb_ack_i/wb_err_i outside BUS are ignored.
- A req_i change during BUS/RESP does not affect the in-flight transaction.
- A port dropping req_i before completion is still completed; valid_o still pulses.
- NUM_PORTS = 1 degenerates to a pass-through with the same latency.

Optional Feature:
TIMEOUT_EN:
- Defined: a counter clears on BUS entry and increments each BUS cycle. If it reaches TIMEOUT_CYCLES-1 without ack/err: drop cyc, go to RESP with err_o = 1 and rdata_o = 0.
- Undefined: no counter; BUS waits indefinitely for ack/err.

Test Plan:
- Single read, port 1 addr 0x0000_1000, slave acks in 1 cycle with 0xCAFE_F00D → cyc high exactly 1 cycle, we=0, wstrb=0; valid_o=2'b10 one cycle later, rdata_o=0xCAFE_F00D, err_o=0.
- Both ports request continuously, zero-wait slave → grants alternate 0,1,0,1; 3 cycles per transaction; each valid_o pulse matches the granted port.
- Port 0 (read-only) requests with we=1, wstrb=4'hF, wdata=0x1234_5678 → bus shows we=0, wstrb=0, data_out=0; port 1 write with wstrb=4'b0011 → bus we=1, wstrb=4'b0011, data 0x1234_5678.
- wb_err_i pulse instead of ack → valid_o with err_o=1; ack and err on the same edge → err_o=0.
- rst_core asserted during BUS with a 5-cycle wait slave → cyc=0 immediately, no valid_o; after release, port 0 is granted first.
- TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks → cyc high exactly 16 cycles, then valid_o with err_o=1, rdata_o=0; without macro cyc remains high for 100+ cycles.
